// File: rtl/final_phase_ctrl.sv
// Sequencer for the final packing/register stage of the FP add/subt unit: holds the
// overflow/underflow selects, pulses the result-register load, then handshakes the result.
module final_phase_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beg_i,
  input  logic             ovf_flag_i,
  input  logic             unf_flag_i,
  input  logic             ack_i,
  output logic             sel_a_o,
  output logic             sel_b_o,
  output logic             load_reg_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic             ovf_o,
  output logic             unf_o,
  output logic [CNT_W-1:0] ovf_cnt_o,
  output logic [CNT_W-1:0] unf_cnt_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StLoad, StDone} state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (beg_i) begin
          // Overflow takes priority when both flags are raised.
          ovf_d    = ovf_flag_i;
          unf_d    = unf_flag_i & ~ovf_flag_i;
          settle_d = SettleInit;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == 4'd0) begin
          state_d = StLoad;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StLoad: begin
        if (ovf_q && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CntOne;
        if (unf_q && (unf_cnt_q != '1)) unf_cnt_d = unf_cnt_q + CntOne;
        state_d = StDone;
      end
      StDone: begin
        if (ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Selects stay driven through LOAD and DONE so the mux output matches the register.
  assign busy_o     = (state_q != StIdle);
  assign sel_a_o    = busy_o & ovf_q;
  assign sel_b_o    = busy_o & unf_q;
  assign load_reg_o = (state_q == StLoad);
  assign ready_o    = (state_q == StDone);
  assign ovf_o      = ready_o & ovf_q;
  assign unf_o      = ready_o & unf_q;
  assign ovf_cnt_o  = ovf_cnt_q;
  assign unf_cnt_o  = unf_cnt_q;

endmodule

// File: tb/tb_final_phase_ctrl.sv
// Directed bench for final_phase_ctrl: per-cycle output vectors against hand-built tables,
// plus a narrow-counter instance for saturation.
module tb_final_phase_ctrl;

  logic clk = 1'b0;
  logic rst, beg_i, ovf_flag_i, unf_flag_i, ack_i;
  logic sel_a_o, sel_b_o, load_reg_o, busy_o, ready_o, ovf_o, unf_o;
  logic [7:0] ovf_cnt_o, unf_cnt_o;
  logic s_sel_a, s_sel_b, s_load, s_busy, s_ready, s_ovf, s_unf;
  logic [1:0] s_ovf_cnt, s_unf_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  final_phase_ctrl #(.SETTLE_CYC(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .beg_i(beg_i), .ovf_flag_i(ovf_flag_i), .unf_flag_i(unf_flag_i),
    .ack_i(ack_i), .sel_a_o(sel_a_o), .sel_b_o(sel_b_o), .load_reg_o(load_reg_o),
    .busy_o(busy_o), .ready_o(ready_o), .ovf_o(ovf_o), .unf_o(unf_o),
    .ovf_cnt_o(ovf_cnt_o), .unf_cnt_o(unf_cnt_o)
  );

  final_phase_ctrl #(.SETTLE_CYC(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .beg_i(beg_i), .ovf_flag_i(ovf_flag_i), .unf_flag_i(unf_flag_i),
    .ack_i(ack_i), .sel_a_o(s_sel_a), .sel_b_o(s_sel_b), .load_reg_o(s_load),
    .busy_o(s_busy), .ready_o(s_ready), .ovf_o(s_ovf), .unf_o(s_unf),
    .ovf_cnt_o(s_ovf_cnt), .unf_cnt_o(s_unf_cnt)
  );

  // {sel_a, sel_b, load, busy, ready, ovf, unf}
  logic [6:0] outs;
  assign outs = {sel_a_o, sel_b_o, load_reg_o, busy_o, ready_o, ovf_o, unf_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; beg_i = 1'b0; ovf_flag_i = 1'b0; unf_flag_i = 1'b0; ack_i = 1'b0;
    tick();
    tick();
    vecs++;
    if (outs !== 7'b0 || ovf_cnt_o !== 8'd0 || unf_cnt_o !== 8'd0) begin
      $display("FAIL reset: outs=%b ovf_cnt=%0d unf_cnt=%0d, want 0000000 0 0",
               outs, ovf_cnt_o, unf_cnt_o);
      errs++;
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (outs !== 7'b0) begin
      $display("FAIL idle_after_reset: outs=%b want 0000000", outs);
      errs++;
    end
  endtask

  // One op: flags at beg, ack raised after checking cycle ack_at, expect per-cycle table.
  task automatic run_op(input string name, input logic ovf, input logic unf, input int ack_at,
                        input logic [6:0] exp_tab [$], input logic [7:0] exp_ovf_cnt,
                        input logic [7:0] exp_unf_cnt);
    beg_i = 1'b1; ovf_flag_i = ovf; unf_flag_i = unf;
    tick();
    beg_i = 1'b0; ovf_flag_i = 1'b0; unf_flag_i = 1'b0;
    for (int c = 1; c <= exp_tab.size(); c++) begin
      vecs++;
      if (outs !== exp_tab[c-1]) begin
        $display("FAIL %s cycle %0d: outs=%b want %b", name, c, outs, exp_tab[c-1]);
        errs++;
      end
      ack_i = (c == ack_at);
      if (c < exp_tab.size()) tick();
    end
    ack_i = 1'b0;
    vecs++;
    if (ovf_cnt_o !== exp_ovf_cnt || unf_cnt_o !== exp_unf_cnt) begin
      $display("FAIL %s counters: ovf=%0d unf=%0d want ovf=%0d unf=%0d", name,
               ovf_cnt_o, unf_cnt_o, exp_ovf_cnt, exp_unf_cnt);
      errs++;
    end
  endtask

  task automatic test_normal();
    run_op("normal", 1'b0, 1'b0, 6,
           '{7'b0001000, 7'b0001000, 7'b0011000, 7'b0001100, 7'b0001100, 7'b0001100,
             7'b0000000}, 8'd0, 8'd0);
  endtask

  task automatic test_overflow();
    run_op("overflow", 1'b1, 1'b0, 6,
           '{7'b1001000, 7'b1001000, 7'b1011000, 7'b1001110, 7'b1001110, 7'b1001110,
             7'b0000000}, 8'd1, 8'd0);
  endtask

  task automatic test_both_flags();
    run_op("both_flags", 1'b1, 1'b1, 6,
           '{7'b1001000, 7'b1001000, 7'b1011000, 7'b1001110, 7'b1001110, 7'b1001110,
             7'b0000000}, 8'd2, 8'd0);
  endtask

  task automatic test_underflow_fast_ack();
    run_op("underflow_fast_ack", 1'b0, 1'b1, 4,
           '{7'b0101000, 7'b0101000, 7'b0111000, 7'b0101101, 7'b0000000}, 8'd2, 8'd1);
  endtask

  // beg_i held high, ack in SETTLE, flags changed after acceptance.
  task automatic test_ignored_inputs();
    logic [6:0] exp_tab [$];
    int loads = 0;
    exp_tab = '{7'b0001000, 7'b0001000, 7'b0011000, 7'b0001100, 7'b0001100, 7'b0001100,
                7'b0000000, 7'b1001000, 7'b1001000, 7'b1011000, 7'b1001110, 7'b0000000};
    beg_i = 1'b1; ovf_flag_i = 1'b0; unf_flag_i = 1'b0;
    tick();
    ovf_flag_i = 1'b1; unf_flag_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      vecs++;
      if (outs !== exp_tab[c-1]) begin
        $display("FAIL ignored cycle %0d: outs=%b want %b", c, outs, exp_tab[c-1]);
        errs++;
      end
      if (load_reg_o) loads++;
      ack_i = (c == 1) || (c == 6) || (c == 11);
      if (c == 8) beg_i = 1'b0;
      if (c < 12) tick();
    end
    ack_i = 1'b0; ovf_flag_i = 1'b0; unf_flag_i = 1'b0;
    vecs++;
    if (loads !== 2) begin
      $display("FAIL ignored load_count: got %0d want 2", loads);
      errs++;
    end
    vecs++;
    if (ovf_cnt_o !== 8'd3 || unf_cnt_o !== 8'd1) begin
      $display("FAIL ignored counters: ovf=%0d unf=%0d want ovf=3 unf=1", ovf_cnt_o, unf_cnt_o);
      errs++;
    end
  endtask

  task automatic test_reset_mid_op();
    beg_i = 1'b1; ovf_flag_i = 1'b1;
    tick();
    beg_i = 1'b0; ovf_flag_i = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (outs !== 7'b0 || ovf_cnt_o !== 8'd0 || unf_cnt_o !== 8'd0) begin
      $display("FAIL reset_mid_op: outs=%b ovf_cnt=%0d unf_cnt=%0d want 0000000 0 0",
               outs, ovf_cnt_o, unf_cnt_o);
      errs++;
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      vecs++;
      if (outs !== 7'b0) begin
        $display("FAIL reset_mid_op after cycle %0d: outs=%b want 0000000", c, outs);
        errs++;
      end
    end
  endtask

  // Back-to-back underflow ops at the minimum issue interval.
  task automatic test_back_to_back_saturation();
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      beg_i = 1'b1; unf_flag_i = 1'b1;
      tick();
      beg_i = 1'b0; unf_flag_i = 1'b0;
      tick(); tick(); tick();
      vecs++;
      if (ready_o !== 1'b1 || unf_o !== 1'b1) begin
        $display("FAIL b2b op %0d ready/unf: ready=%b unf=%b want 1 1", k, ready_o, unf_o);
        errs++;
      end
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      vecs++;
      if (unf_cnt_o !== 8'(k + 1) || s_unf_cnt !== sat_exp[k]) begin
        $display("FAIL sat op %0d: unf_cnt=%0d narrow=%0d want %0d %0d", k, unf_cnt_o,
                 s_unf_cnt, k + 1, sat_exp[k]);
        errs++;
      end
      vecs++;
      if (busy_o !== 1'b0 || s_ovf_cnt !== 2'd0) begin
        $display("FAIL b2b op %0d idle: busy=%b narrow_ovf=%0d want 0 0", k, busy_o, s_ovf_cnt);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_both_flags();
    test_underflow_fast_ack();
    test_ignored_inputs();
    test_reset_mid_op();
    test_back_to_back_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
